// File: rtl/demultiplexer_tdm_1x16.sv
// 1-to-16 time-division demultiplexer: assembles 16 serial slots into a frame,
// with a registered one-hot live view of each accepted sample.
module demultiplexer_tdm_1x16 #(
    parameter bit STRICT_SYNC = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    input  logic        din_valid,
    input  logic        sync,
    output logic [15:0] F,
    output logic        frame_valid,
    output logic [15:0] ch,
    output logic [3:0]  slot,
    output logic        frame_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state,  w_state_nxt;
    logic [3:0]  r_slot,   w_slot_nxt;
    logic [14:0] r_shadow, w_shadow_nxt;
    logic [15:0] r_F,      w_F_nxt;
    logic [15:0] r_ch,     w_ch_nxt;
    logic        r_fv,     w_fv_nxt;
    logic        r_err,    w_err_nxt;
    logic [15:0] w_onehot;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_slot   <= '0;
            r_shadow <= '0;
            r_F      <= '0;
            r_ch     <= '0;
            r_fv     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_slot   <= w_slot_nxt;
            r_shadow <= w_shadow_nxt;
            r_F      <= w_F_nxt;
            r_ch     <= w_ch_nxt;
            r_fv     <= w_fv_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        // Slot 15 selects bit 15, which lies outside the shadow; that sample goes straight into F.
        w_onehot     = 16'h0001 << r_slot;
        w_state_nxt  = r_state;
        w_slot_nxt   = r_slot;
        w_shadow_nxt = r_shadow;
        w_F_nxt      = r_F;
        w_ch_nxt     = '0;
        w_fv_nxt     = 1'b0;
        w_err_nxt    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (din_valid && sync) begin
                    w_state_nxt  = S_RUN;
                    w_shadow_nxt = {14'b0, din};
                    w_slot_nxt   = 4'd1;
                    w_ch_nxt     = {15'b0, din};
                end
            end
            S_RUN: begin
                if (din_valid) begin
                    if (STRICT_SYNC && sync && (r_slot != 4'd0)) begin
                        // Misaligned sync: restart the frame with this sample as slot 0.
                        w_err_nxt    = 1'b1;
                        w_shadow_nxt = {14'b0, din};
                        w_slot_nxt   = 4'd1;
                        w_ch_nxt     = {15'b0, din};
                    end else begin
                        w_ch_nxt     = din ? w_onehot : '0;
                        w_shadow_nxt = din ? (r_shadow | w_onehot[14:0])
                                           : (r_shadow & ~w_onehot[14:0]);
                        if (r_slot == 4'd15) begin
                            w_F_nxt    = {din, r_shadow};
                            w_fv_nxt   = 1'b1;
                            w_slot_nxt = 4'd0;
                        end else begin
                            w_slot_nxt = r_slot + 4'd1;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign F           = r_F;
    assign frame_valid = r_fv;
    assign ch          = r_ch;
    assign slot        = r_slot;
    assign frame_err   = r_err;

endmodule
